// File: rtl/drcv_pkg.sv
// Shared types and constants for the stepdown digital receivers.
package drcv_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_PEND = 2'd1,
        HIGH      = 2'd2,
        FALL_PEND = 2'd3
    } drcv_state_t;

    localparam int unsigned DEB_CYCLES_MIN = 2;
    localparam int unsigned GCNT_W_DEFAULT = 8;

endpackage

// File: rtl/drcv_sync2.sv
// Two-flop synchronizer with a configurable reset level.
module drcv_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/drcv_stepdown_corestate.sv
// Core-state digital receiver: synchronize, debounce, edge strobes and a
// saturating count of aborted pending transitions.
module drcv_stepdown_corestate
    import drcv_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter logic        RST_VAL    = 1'b0,
    parameter int unsigned GCNT_W     = GCNT_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    input  logic              i,
    input  logic              en,
    input  logic              glitch_clr,
    output logic              o,
    output logic              rise,
    output logic              fall,
    output logic [GCNT_W-1:0] glitch_cnt
);

    localparam int unsigned              CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [GCNT_W-1:0]        GCNT_MAX = {GCNT_W{1'b1}};

    drcv_state_t        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_o;
    logic               r_rise;
    logic               r_fall;
    logic [GCNT_W-1:0]  r_gcnt;
    logic               w_s2;
    logic               w_glitch;
    logic               w_unused_pins;

    // Supply/substrate pins exist only for schematic netlisting.
    assign w_unused_pins = CELV ^ CELG ^ SUB;

    drcv_sync2 #(
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .i_d (i),
        .o_q (w_s2)
    );

    // A pending transition that sees the settled level again is a glitch; en=0 aborts are not.
    assign w_glitch = en && (((r_state == RISE_PEND) && !w_s2) ||
                             ((r_state == FALL_PEND) &&  w_s2));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RST_VAL ? HIGH : LOW;
            r_cnt   <= '0;
            r_o     <= RST_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!en) begin
                if (r_state == RISE_PEND) begin
                    r_state <= LOW;
                end else if (r_state == FALL_PEND) begin
                    r_state <= HIGH;
                end
                r_cnt <= '0;
            end else begin
                case (r_state)
                    LOW: begin
                        if (w_s2) begin
                            r_state <= RISE_PEND;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    RISE_PEND: begin
                        if (!w_s2) begin
                            r_state <= LOW;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= HIGH;
                            r_cnt   <= '0;
                            r_o     <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (!w_s2) begin
                            r_state <= FALL_PEND;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    FALL_PEND: begin
                        if (w_s2) begin
                            r_state <= HIGH;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= LOW;
                            r_cnt   <= '0;
                            r_o     <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= RST_VAL ? HIGH : LOW;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Clear wins over a coincident glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_gcnt <= '0;
        end else if (glitch_clr) begin
            r_gcnt <= '0;
        end else if (w_glitch && (r_gcnt != GCNT_MAX)) begin
            r_gcnt <= r_gcnt + GCNT_W'(1);
        end
    end

    assign o          = r_o;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign glitch_cnt = r_gcnt;

endmodule

// File: tb/tb_drcv_stepdown_corestate.sv
// Scoreboard bench: two receivers (DEB=4/RST_VAL=0 and DEB=2/RST_VAL=1) with
// per-cycle expectations queued by the stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_drcv_stepdown_corestate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic cel_v = 1'b1;
    logic cel_g = 1'b0;
    logic sub   = 1'b0;

    logic       rst_a, i_a, en_a, clr_a, o_a, rise_a, fall_a;
    logic [7:0] g_a;
    logic       rst_b, i_b, en_b, clr_b, o_b, rise_b, fall_b;
    logic [7:0] g_b;

    drcv_stepdown_corestate #(.DEB_CYCLES(4), .RST_VAL(1'b0), .GCNT_W(8)) dut_a (
        .CLK(clk), .RST(rst_a), .CELV(cel_v), .CELG(cel_g), .SUB(sub),
        .i(i_a), .en(en_a), .glitch_clr(clr_a),
        .o(o_a), .rise(rise_a), .fall(fall_a), .glitch_cnt(g_a)
    );

    drcv_stepdown_corestate #(.DEB_CYCLES(2), .RST_VAL(1'b1), .GCNT_W(8)) dut_b (
        .CLK(clk), .RST(rst_b), .CELV(cel_v), .CELG(cel_g), .SUB(sub),
        .i(i_b), .en(en_b), .glitch_clr(clr_b),
        .o(o_b), .rise(rise_b), .fall(fall_b), .glitch_cnt(g_b)
    );

    typedef struct {
        int         cyc;
        bit         o;
        bit         r;
        bit         f;
        bit         chk_g;
        logic [7:0] g;
        string      name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   nr_a = 0, nf_a = 0, nr_b = 0, nf_b = 0, n_both = 0;
    bit   done_a = 1'b0;
    bit   done_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit b, input int c, input bit o, input bit r, input bit f,
                        input bit cg, input logic [7:0] g, input string nm);
        exp_t e;
        e.cyc = c; e.o = o; e.r = r; e.f = f; e.chk_g = cg; e.g = g; e.name = nm;
        if (b) q_b.push_back(e);
        else   q_a.push_back(e);
    endtask

    task automatic push_rng(input bit b, input int c0, input int c1, input bit o, input bit r,
                            input bit f, input bit cg, input logic [7:0] g, input string nm);
        for (int c = c0; c <= c1; c++) push(b, c, o, r, f, cg, g, nm);
    endtask

    task automatic cmp_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Pop and compare every expectation due at the current cycle.
    task automatic serve(input bit b, input logic o, input logic r, input logic f,
                         input logic [7:0] g);
        exp_t        e;
        logic [10:0] act;
        logic [10:0] exv;
        logic [10:0] msk;
        forever begin
            if (b ? (q_b.size() == 0) : (q_a.size() == 0)) break;
            e = b ? q_b[0] : q_a[0];
            if (e.cyc > cyc) break;
            if (b) void'(q_b.pop_front());
            else   void'(q_a.pop_front());
            n_chk++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
            end else begin
                act = {o, r, f, g};
                exv = {e.o, e.r, e.f, e.g};
                msk = e.chk_g ? 11'h7FF : 11'h700;
                if (((act ^ exv) & msk) !== 11'd0) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got o/rise/fall/gcnt=%b/%b/%b/%0d expected %b/%b/%b/%0d%s",
                             e.name, cyc, o, r, f, g, e.o, e.r, e.f, e.g,
                             e.chk_g ? "" : " (gcnt ignored)");
                end
            end
        end
    endtask

    always @(negedge clk) begin
        serve(1'b0, o_a, rise_a, fall_a, g_a);
        serve(1'b1, o_b, rise_b, fall_b, g_b);
        if (rise_a === 1'b1) nr_a++;
        if (fall_a === 1'b1) nf_a++;
        if (rise_b === 1'b1) nr_b++;
        if (fall_b === 1'b1) nf_b++;
        if ((rise_a === 1'b1 && fall_a === 1'b1) || (rise_b === 1'b1 && fall_b === 1'b1)) n_both++;
    end

    function automatic bit ival(input int k);
        if (k < 1 || k > 12) return 1'b1;
        return (((k - 1) / 3) % 2) == 1;
    endfunction

    initial begin : stim_a
        int t;
        rst_a = 1'b1; i_a = 1'b0; en_a = 1'b1; clr_a = 1'b0;
        repeat (3) tick();
        push(0, cyc, 0, 0, 0, 1, 8'd0, "a_reset");
        tick();
        rst_a = 1'b0;
        repeat (2) tick();

        // Rise latency: o and rise after edge 6.
        t = cyc;
        push_rng(0, t + 1, t + 5, 0, 0, 0, 1, 8'd0, "a_rise_wait");
        push(0, t + 6, 1, 1, 0, 1, 8'd0, "a_rise_edge");
        push(0, t + 7, 1, 0, 0, 1, 8'd0, "a_rise_done");
        i_a = 1'b1;
        repeat (10) tick();

        // Two-cycle low pulse in HIGH is filtered and counted.
        t = cyc;
        push_rng(0, t + 1, t + 4, 1, 0, 0, 1, 8'd0, "a_hi_glitch_pre");
        push_rng(0, t + 5, t + 7, 1, 0, 0, 1, 8'd1, "a_hi_glitch_post");
        i_a = 1'b0;
        repeat (2) tick();
        i_a = 1'b1;
        repeat (6) tick();

        // Settle to LOW.
        t = cyc;
        push_rng(0, t + 1, t + 5, 1, 0, 0, 1, 8'd1, "a_fall_wait");
        push(0, t + 6, 0, 0, 1, 1, 8'd1, "a_fall_edge");
        push(0, t + 7, 0, 0, 0, 1, 8'd1, "a_fall_done");
        i_a = 1'b0;
        repeat (10) tick();

        // 300 single-cycle glitches: counter saturates at 255.
        t = cyc;
        push_rng(0, t + 1, t + 2, 0, 0, 0, 0, 8'd0, "a_sat_lvl");
        for (int j = 0; j < 300; j++) begin
            push(0, t + 3 + 2 * j, 0, 0, 0, 0, 8'd0, "a_sat_lvl");
            push(0, t + 4 + 2 * j, 0, 0, 0, 1, 8'((j + 2 > 255) ? 255 : j + 2), "a_sat_cnt");
        end
        for (int j = 0; j < 300; j++) begin
            i_a = 1'b1;
            tick();
            i_a = 1'b0;
            tick();
        end
        repeat (4) tick();

        // Clear coincident with a glitch increment yields 0.
        t = cyc;
        push(0, t + 3, 0, 0, 0, 1, 8'd255, "a_clr_pre");
        push(0, t + 4, 0, 0, 0, 1, 8'd0, "a_clr_prio");
        push(0, t + 5, 0, 0, 0, 1, 8'd0, "a_clr_post");
        i_a = 1'b1;
        tick();
        i_a = 1'b0;
        repeat (2) tick();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        repeat (3) tick();

        // en=0 aborts RISE_PEND without a glitch; full restart follows.
        t = cyc;
        push_rng(0, t + 1, t + 8, 0, 0, 0, 1, 8'd0, "a_en_abort");
        push(0, t + 9, 1, 1, 0, 1, 8'd0, "a_en_restart_rise");
        push(0, t + 10, 1, 0, 0, 1, 8'd0, "a_en_restart_done");
        i_a = 1'b1;
        repeat (4) tick();
        en_a = 1'b0;
        tick();
        en_a = 1'b1;
        repeat (8) tick();
        done_a = 1'b1;
    end

    initial begin : stim_b
        int t;
        bit ok;
        bit op;
        rst_b = 1'b1; i_b = 1'b1; en_b = 1'b1; clr_b = 1'b0;
        repeat (3) tick();
        push(1, cyc, 1, 0, 0, 1, 8'd0, "b_reset");
        tick();
        rst_b = 1'b0;
        repeat (3) tick();

        // DEB=2, input toggling every 3 cycles: o follows 3 edges later.
        t = cyc;
        for (int k = 1; k <= 16; k++) begin
            ok = ival(k - 3);
            op = ival(k - 4);
            push(1, t + k, ok, ok & ~op, ~ok & op, 1, 8'd0, "b_toggle");
        end
        for (int k = 1; k <= 16; k++) begin
            i_b = ival(k);
            tick();
        end
        repeat (3) tick();

        // One-cycle low pulse in HIGH aborts FALL_PEND as a glitch.
        t = cyc;
        push_rng(1, t + 1, t + 3, 1, 0, 0, 1, 8'd0, "b_glitch_pre");
        push_rng(1, t + 4, t + 5, 1, 0, 0, 1, 8'd1, "b_glitch_post");
        i_b = 1'b0;
        tick();
        i_b = 1'b1;
        repeat (6) tick();

        // Async reset mid-FALL_PEND: o stays 1, no fall, counter cleared at once.
        t = cyc;
        push_rng(1, t + 1, t + 2, 1, 0, 0, 1, 8'd1, "b_rst_pre");
        push_rng(1, t + 3, t + 9, 1, 0, 0, 1, 8'd0, "b_rst_mid_pend");
        i_b = 1'b0;
        repeat (3) tick();
        rst_b = 1'b1;
        repeat (2) tick();
        i_b = 1'b1;
        rst_b = 1'b0;
        repeat (5) tick();
        done_b = 1'b1;
    end

    initial begin : main
        wait (done_a && done_b);
        repeat (4) tick();
        cmp_int("a_queue_drained", q_a.size(), 0);
        cmp_int("b_queue_drained", q_b.size(), 0);
        cmp_int("a_rise_strobes", nr_a, 2);
        cmp_int("a_fall_strobes", nf_a, 1);
        cmp_int("b_rise_strobes", nr_b, 2);
        cmp_int("b_fall_strobes", nf_b, 2);
        cmp_int("rise_fall_overlap", n_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: stimulus did not complete (done_a=%0b done_b=%0b)", done_a, done_b);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/drcv_stepdown_corestate.md
Name: drcv_stepdown_corestate

Overview:
- Digital receiver: the input-side counterpart of the core-state digital buffer.
- Takes an asynchronous logic-level signal `i` from the stepdown analog/core-state domain and synchronizes it to CLK.
- Deglitches it with a debounce FSM and presents a clean level `o`, plus one-cycle edge strobes and a saturating glitch counter.
- Sits between analog comparator/flag outputs and the stepdown digital control logic.

Parameters:
- DEB_CYCLES, 4, consecutive synchronized cycles a new level must hold before `o` changes; legal range 2..255.
- CNT_W, $clog2(DEB_CYCLES+1), debounce counter width; derived, not overridden.
- RST_VAL, 0, reset/initial level of `o` and of the FSM settled state.
- GCNT_W, 8, glitch counter width.

Ports:
- CLK  input  1  single system clock, rising edge active.
- RST  input  1  asynchronous active-high reset.
- CELV  input  1  supply pin; pass-through, no logic function.
- CELG  input  1  ground pin; pass-through, no logic function.
- SUB  input  1  substrate pin; pass-through, no logic function.
- i  input  1  asynchronous raw input level.
- en  input  1  receiver enable; 0 = hold.
- glitch_clr  input  1  synchronous clear of glitch_cnt.
- o  output  1  debounced level.
- rise  output  1  one-cycle strobe when `o` goes 0->1.
- fall  output  1  one-cycle strobe when `o` goes 1->0.
- glitch_cnt  output  GCNT_W  count of aborted pending transitions, saturating.

Behaviour:
- Reset (asynchronous, RST=1):
  - Sync flops s1 and s2 load RST_VAL.
  - FSM goes to LOW if RST_VAL=0, otherwise HIGH.
  - cnt=0; o=RST_VAL; rise=0; fall=0; glitch_cnt=0.
  - Release is synchronous to CLK at the next edge.
- Synchronizer: 2-flop chain, `i`->s1->s2, free-running whenever RST=0, independent of `en`. Only s2 feeds the FSM.
- FSM states: LOW, RISE_PEND, HIGH, FALL_PEND. Transitions apply when en=1:
  - LOW: s2=1 -> RISE_PEND, cnt=1; else stay.
  - RISE_PEND, s2=1, cnt=DEB_CYCLES-1 -> HIGH, o=1, rise=1 for one cycle.
  - RISE_PEND, s2=1, otherwise -> cnt+1.
  - RISE_PEND, s2=0 -> LOW, cnt=0, glitch_cnt+1.
  - HIGH and FALL_PEND: mirror images of LOW and RISE_PEND (o=0, fall strobe).
- Latency: `i` stable high set up before edge N gives o=1 and rise=1 after edge N+1+DEB_CYCLES. Example: DEB_CYCLES=4, `i` high before edge 1 -> o and rise asserted after edge 6.
- o, rise and fall are registered outputs; no combinational path from `i`.
- rise and fall are never both 1. Each is 1 for exactly one cycle per transition of `o`.
- en=0:
  - A PEND state aborts to its settled state (RISE_PEND->LOW, FALL_PEND->HIGH) with cnt=0.
  - Aborts caused by en=0 do not count as glitches.
  - o holds; rise and fall are 0.
  - Settled states hold.
- glitch_cnt:
  - Saturates at 2^GCNT_W-1.
  - glitch_clr=1 forces 0 next edge.
  - glitch_clr has priority over a simultaneous increment, i.e. the result is 0.
- Reset mid-PEND: immediately returns to the RST_VAL settled state. No strobe is generated.
- Supply pins CELV, CELG and SUB are unused in RTL; they are kept for schematic-generator netlisting.

Decomposition:
- Shared package drcv_pkg:
  - state enum drcv_state_t {LOW, RISE_PEND, HIGH, FALL_PEND}.
  - DEB_CYCLES_MIN=2 constant.
  - GCNT_W default.
- One sub-module drcv_sync2: the 2-flop synchronizer with RST_VAL parameter and async reset. It is reused by other stepdown receivers.
- The FSM, counter and strobes stay in the top module.

Test Plan:
- Reset with RST_VAL=0, then `i` held 1 from edge 1 (DEB_CYCLES=4) -> o=0 through edge 5; o=1 and rise=1 after edge 6; rise=0 after edge 7.
- In HIGH, `i` pulses 0 for 2 cycles (DEB_CYCLES=4) -> o stays 1; fall never asserted; glitch_cnt=1.
- 300 single-cycle glitches while in LOW -> glitch_cnt saturates at 255. Then glitch_clr coincident with a glitch -> glitch_cnt=0.
- `i` high 2 cycles into RISE_PEND, then en=0 for 1 cycle, then en=1 with `i` still high -> FSM back in LOW; glitch_cnt unchanged; o=1 after a full DEB_CYCLES restart.
- RST asserted asynchronously mid-FALL_PEND with RST_VAL=1 -> o=1 immediately; no fall strobe; glitch_cnt=0.
- DEB_CYCLES=2 with `i` toggling every 3 cycles -> o follows with 3-cycle delay; each transition produces exactly one rise or fall strobe.
